// File: rtl/t_column_store.sv
// T-column word store shared between passes of the systolic PE array.
// Loaded once with the raw T sequence (v=f=0), then serves words to the
// data processor with a fixed 2-cycle read response and absorbs the
// finished-column words written back for the next pass.
module t_column_store #(
  parameter int WORD_W     = 128,
  parameter int HEADER_W   = 3,
  parameter int GROUP_W    = 30,
  parameter int T_PER_WORD = 4,
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 8,
  parameter int TSIZE_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TSIZE_W-1:0] i_T_size,
  input  logic              i_load_valid,
  input  logic [1:0]        i_load_t,
  output logic              o_load_ready,
  input  logic              i_request,
  output logic [WORD_W-1:0] o_request_data,
  input  logic              i_send,
  input  logic [WORD_W-1:0] i_send_data,
  input  logic              i_clear,
  output logic              o_busy,
  output logic              o_overflow
);

  localparam int GROUPS_W = GROUP_W * T_PER_WORD;
  localparam int PAD_W    = WORD_W - HEADER_W - GROUPS_W;
  localparam int SLOT_W   = $clog2(T_PER_WORD);
  localparam int CNT_W    = HEADER_W - 1;
  localparam int OCC_W    = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t              state_q, state_d;
  logic [GROUPS_W-1:0] mem [DEPTH];
  logic [GROUPS_W-1:0] pack_q, pack_d;
  logic [SLOT_W-1:0]   slot_q;
  logic [TSIZE_W-1:0]  sym_cnt_q;
  logic [OCC_W-1:0]    n_words_q, n_words_calc, occ_q;
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q, rd_addr_q, wr_next;
  logic                rd_pend_q, rd_last_q, rd_at_last;
  logic                load_ready_q, overflow_q;
  logic [WORD_W-1:0]   resp_q;
  logic [CNT_W-1:0]    last_cnt, resp_cnt;

  logic                load_acc, last_sym, slot_full, load_wr;
  logic                issue, send_ok, drop, mem_we;
  logic [GROUPS_W-1:0] mem_wdata;
  logic                unused_hdr;

  // Header bits of written-back words are regenerated on read, not stored.
  assign unused_hdr   = ^i_send_data[WORD_W-1:GROUPS_W];

  assign last_sym     = (sym_cnt_q + 1'b1) == i_T_size;
  assign slot_full    = slot_q == SLOT_W'(T_PER_WORD - 1);
  assign n_words_calc = OCC_W'((int'(i_T_size) + T_PER_WORD - 1) / T_PER_WORD);
  assign last_cnt     = CNT_W'(int'(i_T_size) % T_PER_WORD);
  assign rd_at_last   = {1'b0, rd_ptr_q} == (n_words_q - 1'b1);
  assign wr_next      = ({1'b0, wr_ptr_q} == (n_words_q - 1'b1)) ? '0 : wr_ptr_q + 1'b1;
  assign resp_cnt     = rd_last_q ? last_cnt : '0;

  assign load_wr      = load_acc && (slot_full || last_sym);
  assign mem_we       = load_wr || send_ok;
  assign mem_wdata    = load_wr ? pack_d : i_send_data[GROUPS_W-1:0];

  assign o_load_ready   = load_ready_q;
  assign o_request_data = resp_q;
  assign o_busy         = state_q != IDLE;
  assign o_overflow     = overflow_q;

  // Pack register next value: new symbol dropped into its MSB-first slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pack_d = (slot_q == '0) ? '0 : pack_q;
    pack_d[GROUP_W*(T_PER_WORD - int'(slot_q)) - 1 -: GROUP_W] =
      {i_load_t, {(GROUP_W-2){1'b0}}};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle action strobes; i_clear overrides everything.
  always_comb begin
    state_d  = state_q;
    load_acc = 1'b0;
    issue    = 1'b0;
    send_ok  = 1'b0;
    drop     = 1'b0;
    case (state_q)
      IDLE: if (i_load_valid) begin
        load_acc = 1'b1;
        state_d  = last_sym ? RUN : LOAD;
      end
      LOAD: if (i_load_valid) begin
        load_acc = 1'b1;
        if (last_sym) state_d = RUN;
      end
      RUN: begin
        issue = i_request && (occ_q != '0) && !rd_pend_q && !resp_q[WORD_W-1];
        if (i_send) begin
          if (occ_q == n_words_q) drop    = 1'b1;
          else                    send_ok = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (i_clear) begin
      state_d  = IDLE;
      load_acc = 1'b0;
      issue    = 1'b0;
      send_ok  = 1'b0;
      drop     = 1'b0;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the word array has no reset; only pointers/occupancy define which words are meaningful.
    if (mem_we) mem[wr_ptr_q] <= mem_wdata;
  end

  // Pointers, occupancy, load packing and the two-stage read response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q       <= '0;
      slot_q       <= '0;
      sym_cnt_q    <= '0;
      n_words_q    <= '0;
      occ_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_addr_q    <= '0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      load_ready_q <= 1'b1;
      overflow_q   <= 1'b0;
      resp_q       <= '0;
    end else if (i_clear) begin
      pack_q       <= '0;
      slot_q       <= '0;
      sym_cnt_q    <= '0;
      occ_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      load_ready_q <= 1'b1;
      overflow_q   <= 1'b0;
      resp_q       <= '0;
    end else begin
      if (load_acc) begin
        pack_q <= pack_d;
        if (state_q == IDLE) n_words_q <= n_words_calc;
        if (last_sym) begin
          slot_q       <= '0;
          sym_cnt_q    <= '0;
          load_ready_q <= 1'b0;
        end else begin
          slot_q    <= slot_full ? '0 : slot_q + 1'b1;
          sym_cnt_q <= sym_cnt_q + 1'b1;
        end
      end
      if (load_wr)      wr_ptr_q <= last_sym ? '0 : wr_ptr_q + 1'b1;
      else if (send_ok) wr_ptr_q <= wr_next;
      occ_q     <= occ_q + OCC_W'(mem_we) - OCC_W'(issue);
      rd_pend_q <= issue;
      if (issue) begin
        rd_addr_q <= rd_ptr_q;
        rd_last_q <= rd_at_last;
        rd_ptr_q  <= rd_at_last ? '0 : rd_ptr_q + 1'b1;
      end
      resp_q <= rd_pend_q ? {1'b1, resp_cnt, {PAD_W{1'b0}}, mem[rd_addr_q]} : '0;
      if (drop) overflow_q <= 1'b1;
    end
  end

endmodule
